// File: rtl/sa_operand_feeder.sv
// Operand edge feeder for one side of the INT8 systolic array.
// Accepts packed operand vectors over valid/ready, skews lane i by i cycles
// so matching operands meet inside the PEs, and sequences the array's
// COMPUTE/FLUSH controls for one tile: stream, skew drain, flush, done.
module sa_operand_feeder #(
    parameter int N_LANES      = 4,
    parameter int OPND_BWIDTH  = 8,
    parameter int K_BWIDTH     = 16,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                           CLK,
    input  logic                           RSTn,
    input  logic                           STALL,
    input  logic                           START,
    input  logic [K_BWIDTH-1:0]            K_LEN,
    input  logic                           VEC_valid,
    output logic                           VEC_ready,
    input  logic [N_LANES*OPND_BWIDTH-1:0] VEC_data,
    output logic [N_LANES*OPND_BWIDTH-1:0] OPND_out,
    output logic [N_LANES-1:0]             OPND_is_valid_out,
    output logic                           COMPUTE,
    output logic                           FLUSH,
    output logic                           BUSY,
    output logic                           DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [K_BWIDTH-1:0] K_ONE      = K_BWIDTH'(1);
    localparam logic [K_BWIDTH-1:0] DRAIN_LAST = K_BWIDTH'(N_LANES - 1);
    localparam logic [K_BWIDTH-1:0] FLUSH_LAST = K_BWIDTH'(FLUSH_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [K_BWIDTH-1:0] r_cnt;
    logic [K_BWIDTH-1:0] w_cnt_nxt;
    logic [K_BWIDTH-1:0] r_k_len;
    logic [K_BWIDTH-1:0] w_k_len_nxt;
    logic                w_xfer;

    // Control registers: state, phase counter and latched tile length.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_k_len <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_k_len <= w_k_len_nxt;
        end
    end

    // Next-state and control outputs; a stall keeps every next value equal to the current one.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_len_nxt = r_k_len;
        VEC_ready   = 1'b0;
        COMPUTE     = 1'b0;
        FLUSH       = 1'b0;
        BUSY        = 1'b1;
        DONE        = 1'b0;
        case (r_state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (START && !STALL) begin
                    if (K_LEN != '0) begin
                        w_k_len_nxt = K_LEN;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_STREAM;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_STREAM: begin
                COMPUTE   = 1'b1;
                VEC_ready = !STALL;
                if (VEC_valid && !STALL) begin
                    if (r_cnt == r_k_len - K_ONE) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_cnt_nxt = r_cnt + K_ONE;
                    end
                end
            end
            S_DRAIN: begin
                COMPUTE = 1'b1;
                if (!STALL) begin
                    if (r_cnt == DRAIN_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_FLUSH;
                    end else begin
                        w_cnt_nxt = r_cnt + K_ONE;
                    end
                end
            end
            S_FLUSH: begin
                FLUSH = 1'b1;
                if (!STALL) begin
                    if (r_cnt == FLUSH_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + K_ONE;
                    end
                end
            end
            S_DONE: begin
                DONE = 1'b1;
                if (!STALL) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_xfer = VEC_valid & VEC_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic [OPND_BWIDTH-1:0] r_data [0:gi];
            logic [gi:0]            r_vld;

            // Lane delay line of depth gi+1; bubbles carry zero data with valid low.
            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn) begin
                    // NOTE: these arrays are plain flops, not RAM, so resetting them
                    // is cheap and guarantees clean operands and valids after reset.
                    for (int j = 0; j <= gi; j++) begin
                        r_data[j] <= '0;
                    end
                    r_vld <= '0;
                end else if (!STALL) begin
                    r_data[0] <= w_xfer ? VEC_data[gi*OPND_BWIDTH +: OPND_BWIDTH] : '0;
                    r_vld[0]  <= w_xfer;
                    for (int j = 1; j <= gi; j++) begin
                        r_data[j] <= r_data[j-1];
                        r_vld[j]  <= r_vld[j-1];
                    end
                end
            end

            assign OPND_out[gi*OPND_BWIDTH +: OPND_BWIDTH] = r_data[gi];
            assign OPND_is_valid_out[gi]                   = r_vld[gi];
        end
    endgenerate

endmodule

// File: tb/tb_sa_operand_feeder.sv
// Self-checking bench for sa_operand_feeder: directed tiles plus randomized
// tiles, compared every cycle against a shift-history reference model.
module tb_sa_operand_feeder;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int KW = 16;
    localparam int F  = 4;
    localparam int HMAX = 4096;

    logic            CLK = 1'b0;
    logic            RSTn = 1'b0;
    logic            STALL = 1'b0;
    logic            START = 1'b0;
    logic [KW-1:0]   K_LEN = '0;
    logic            VEC_valid = 1'b0;
    logic            VEC_ready;
    logic [N*W-1:0]  VEC_data = '0;
    logic [N*W-1:0]  OPND_out;
    logic [N-1:0]    OPND_is_valid_out;
    logic            COMPUTE;
    logic            FLUSH;
    logic            BUSY;
    logic            DONE;

    sa_operand_feeder #(
        .N_LANES(N), .OPND_BWIDTH(W), .K_BWIDTH(KW), .FLUSH_CYCLES(F)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .STALL(STALL), .START(START), .K_LEN(K_LEN),
        .VEC_valid(VEC_valid), .VEC_ready(VEC_ready), .VEC_data(VEC_data),
        .OPND_out(OPND_out), .OPND_is_valid_out(OPND_is_valid_out),
        .COMPUTE(COMPUTE), .FLUSH(FLUSH), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: s counts non-stalled edges since reset, hist records what
    // entered the array edge on each such edge, and the tile phase is derived
    // arithmetically from the edge of the START and of the final transfer.
    typedef enum int {P_IDLE, P_STREAM, P_DRAIN, P_FLUSH, P_DONE} phase_t;
    int             s = 0;
    logic [N*W-1:0] hist_d [0:HMAX-1];
    logic           hist_v [0:HMAX-1];
    bit             act = 1'b0;
    bit             zero_len = 1'b0;
    int             s_start = 0;
    int             s_last = -1;
    int             k_lat = 0;
    int             n_xfer = 0;
    int             n_compute = 0;
    int             n_flush = 0;
    int             n_done = 0;

    function automatic phase_t phase();
        int d;
        if (!act) return P_IDLE;
        if (zero_len) return (s == s_start) ? P_DONE : P_IDLE;
        if (s_last < 0) return P_STREAM;
        d = s - s_last;
        if (d < N) return P_DRAIN;
        if (d < N + F) return P_FLUSH;
        if (d == N + F) return P_DONE;
        return P_IDLE;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input phase_t ph, input bit st);
        logic [N*W-1:0] ed;
        logic [N*W-1:0] m;
        logic [N-1:0]   ev;
        ed = '0;
        m  = '0;
        ev = '0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = s - i;
            if (idx >= 1) begin
                ev[i]         = hist_v[idx];
                ed[i*W +: W]  = hist_d[idx][i*W +: W];
            end
            m[i*W +: W] = {W{ev[i]}};
        end
        check("opnd_valid", 64'(OPND_is_valid_out), 64'(ev));
        check("opnd_data",  64'(OPND_out & m),      64'(ed & m));
        check("compute",    64'(COMPUTE), 64'(ph == P_STREAM || ph == P_DRAIN));
        check("flush",      64'(FLUSH),   64'(ph == P_FLUSH));
        check("busy",       64'(BUSY),    64'(ph != P_IDLE));
        check("done",       64'(DONE),    64'(ph == P_DONE));
        check("vec_ready",  64'(VEC_ready), 64'(ph == P_STREAM && !st));
        check("compute_and_flush", 64'(COMPUTE & FLUSH), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_opnd"},    64'(OPND_out),          64'(0));
        check({tag, "_valid"},   64'(OPND_is_valid_out), 64'(0));
        check({tag, "_ready"},   64'(VEC_ready), 64'(0));
        check({tag, "_compute"}, 64'(COMPUTE),   64'(0));
        check({tag, "_flush"},   64'(FLUSH),     64'(0));
        check({tag, "_busy"},    64'(BUSY),      64'(0));
        check({tag, "_done"},    64'(DONE),      64'(0));
    endtask

    task automatic model_reset();
        s = 0;
        act = 1'b0;
        zero_len = 1'b0;
        s_last = -1;
        n_xfer = 0;
    endtask

    // One clock cycle: drive at negedge, check just after, advance model at posedge.
    task automatic cyc(input bit st, input bit sr, input logic [KW-1:0] kl,
                       input bit vv, input logic [N*W-1:0] vd);
        phase_t ph;
        bit     xfer;
        @(negedge CLK);
        STALL = st; START = sr; K_LEN = kl; VEC_valid = vv; VEC_data = vd;
        #1;
        ph = phase();
        check_outputs(ph, st);
        if (!st) begin
            if (COMPUTE) n_compute++;
            if (FLUSH)   n_flush++;
            if (DONE)    n_done++;
        end
        xfer = (ph == P_STREAM) && vv && !st;
        @(posedge CLK);
        if (!st && s < HMAX - 1) begin
            s++;
            hist_v[s] = xfer;
            hist_d[s] = xfer ? vd : '0;
            if (ph == P_IDLE && sr) begin
                act = 1'b1; zero_len = (kl == '0); s_start = s;
                s_last = -1; k_lat = int'(kl); n_xfer = 0;
            end
            if (xfer) begin
                n_xfer++;
                if (n_xfer == k_lat) s_last = s;
            end
            if (act && phase() == P_IDLE) act = 1'b0;
        end
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic run_rand_tile(input logic [KW-1:0] k);
        cyc(1'b0, 1'b1, k, 1'b0, '0);
        for (int i = 0; i < 400 && act; i++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                KW'($urandom_range(0, 9)), $urandom_range(0, 2) != 0, $urandom);
        end
        run_idle(1);
        check("rand_tile_ended", 64'(BUSY), 64'(0));
    endtask

    initial begin
        // Reset state.
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        model_reset();
        run_idle(2);

        // Basic tile: K=3, valid always high, spec vectors.
        n_compute = 0; n_flush = 0; n_done = 0;
        cyc(1'b0, 1'b1, 16'd3, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, 1'b1, 32'h03020100);
        cyc(1'b0, 1'b0, '0, 1'b1, 32'h13121110);
        cyc(1'b0, 1'b0, '0, 1'b1, 32'h23222120);
        run_idle(12);
        check("basic_compute_cycles", 64'(n_compute), 64'(7));
        check("basic_flush_cycles",   64'(n_flush),   64'(4));
        check("basic_done_pulses",    64'(n_done),    64'(1));

        // Bubble: K=2, valid 1,0,1.
        cyc(1'b0, 1'b1, 16'd2, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, 1'b1, $urandom);
        cyc(1'b0, 1'b0, '0, 1'b0, $urandom);
        cyc(1'b0, 1'b0, '0, 1'b1, $urandom);
        run_idle(12);

        // Stall for 3 cycles after the first transfer.
        n_compute = 0;
        cyc(1'b0, 1'b1, 16'd3, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, 1'b1, 32'h03020100);
        repeat (3) cyc(1'b1, 1'b0, '0, 1'b1, 32'h13121110);
        cyc(1'b0, 1'b0, '0, 1'b1, 32'h13121110);
        cyc(1'b0, 1'b0, '0, 1'b1, 32'h23222120);
        run_idle(12);
        check("stall_compute_cycles", 64'(n_compute), 64'(7));

        // Zero-length tile, and START ignored while stalled in IDLE.
        cyc(1'b1, 1'b1, 16'd5, 1'b0, '0);
        cyc(1'b0, 1'b1, 16'd0, 1'b1, $urandom);
        run_idle(3);

        // START with K_LEN=9 during DRAIN is ignored.
        cyc(1'b0, 1'b1, 16'd2, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, 1'b1, $urandom);
        cyc(1'b0, 1'b0, '0, 1'b1, $urandom);
        cyc(1'b0, 1'b1, 16'd9, 1'b1, $urandom);
        run_idle(16);

        // Randomized tiles with stalls, bubbles and spurious STARTs.
        for (int t = 0; t < 8; t++) run_rand_tile(KW'($urandom_range(1, 6)));

        // Asynchronous reset in STREAM with two transfers done.
        cyc(1'b0, 1'b1, 16'd6, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, 1'b1, $urandom);
        cyc(1'b0, 1'b0, '0, 1'b1, $urandom);
        @(negedge CLK);
        STALL = 1'b0; START = 1'b0; VEC_valid = 1'b0;
        #2;
        RSTn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        run_idle(3);
        run_rand_tile(16'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
